alu_sched: RTL and testbench

//  Two-requester scheduler for the shared 8-bit combinational ALU (ops: AND,OR,XOR,NAND,NOR,ADD,SUB,MUL,DIV).

---
 rtl/alu_sched_pkg.sv | 25 ++
 rtl/alu_rr_arb.sv | 31 +++
 rtl/alu_sched.sv | 130 +++++++++++++
 tb/tb_alu_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-requester ALU scheduler: function codes,
// FSM state encoding and default widths.
package alu_sched_pkg;

  localparam int W_DEF    = 8;
  localparam int FN_W_DEF = 4;
  localparam int CNT_W    = 4;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_NAND = 3;
  localparam int OP_NOR  = 4;
  localparam int OP_ADD  = 5;
  localparam int OP_SUB  = 6;
  localparam int OP_MUL  = 7;
  localparam int OP_DIV  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin picker. The pointer names the requester with priority
// and moves to the other requester whenever a grant is taken.
module alu_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  // Pick the pointed-to requester first, fall back to the other one.
  always_comb begin
    grant = 2'b00;
    if (ptr == 1'b0) begin
      if (valid[0])      grant = 2'b01;
      else if (valid[1]) grant = 2'b10;
    end else begin
      if (valid[1])      grant = 2'b10;
      else if (valid[0]) grant = 2'b01;
    end
  end

  // Hand priority to the requester that did not win this grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ptr <= 1'b0;
    else if (advance && |grant) ptr <= grant[0];
  end

endmodule

// File: rtl/alu_sched.sv
// Scheduler for a shared external ALU: round-robin accept from two
// requesters, hold operands on the ALU for ALU_LAT cycles, capture the result
// and return it on a valid/ready response port.
// Optional feature: define ALU_DIVZERO_CHK_EN to flag DIV with b==0 as an
// error (alu_f driven 0, rsp_err=1). Without it, div-by-zero only forces
// rsp_y to 0.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int FN_W    = FN_W_DEF,
  parameter int ALU_LAT = 1,
  parameter int OP_MAX  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [FN_W-1:0] req0_f,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [FN_W-1:0] req1_f,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W:0]      rsp_y,
  output logic            rsp_id,
  output logic            rsp_err,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [FN_W-1:0] alu_f,
  input  logic [W:0]      alu_y,
  output logic            busy
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        grant;
  logic              take;
  logic [FN_W-1:0]   sel_f;
  logic [W-1:0]      sel_a, sel_b;
  logic              sel_illegal, sel_divz;
  logic              sel_kill_f, sel_err, sel_zero;
  logic              op_id, op_err, op_zero;

  alu_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   ({req1_valid, req0_valid}),
    .advance (take),
    .grant   (grant)
  );

  assign take       = (state == IDLE) && (|grant);
  assign req0_ready = take & grant[0];
  assign req1_ready = take & grant[1];
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  // Select the granted request and classify its function code.
  always_comb begin
    sel_f       = grant[1] ? req1_f : req0_f;
    sel_a       = grant[1] ? req1_a : req0_a;
    sel_b       = grant[1] ? req1_b : req0_b;
    sel_illegal = (sel_f > FN_W'(OP_MAX));
    sel_divz    = (sel_f == FN_W'(OP_DIV)) && (sel_b == '0);
`ifdef ALU_DIVZERO_CHK_EN
    sel_kill_f  = sel_illegal | sel_divz;
    sel_err     = sel_illegal | sel_divz;
`else
    sel_kill_f  = sel_illegal;
    sel_err     = sel_illegal;
`endif
    // The ALU output is meaningless for b==0, so the result is zeroed either way.
    sel_zero    = sel_illegal | sel_divz;
  end

  // Next-state logic: accept, wait out the ALU latency, wait for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = EXEC;
      EXEC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand/result registers: load the ALU on a grant, capture on the last EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_f   <= '0;
      cnt     <= '0;
      op_id   <= 1'b0;
      op_err  <= 1'b0;
      op_zero <= 1'b0;
      rsp_y   <= '0;
      rsp_id  <= 1'b0;
      rsp_err <= 1'b0;
    end else if (take) begin
      alu_a   <= sel_a;
      alu_b   <= sel_b;
      alu_f   <= sel_kill_f ? '0 : sel_f;
      cnt     <= CNT_W'(ALU_LAT - 1);
      op_id   <= grant[1];
      op_err  <= sel_err;
      op_zero <= sel_zero;
    end else if (state == EXEC) begin
      if (cnt == '0) begin
        rsp_y   <= op_zero ? '0 : alu_y;
        rsp_id  <= op_id;
        rsp_err <= op_err;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched. A behavioural ALU model drives
// alu_y from alu_a/b/f; a second instance with ALU_LAT=4 is used for the
// mid-operation reset scenario.
module tb_alu_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [3:0] req0_f = '0, req1_f = '0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;

  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy;
  logic [8:0] rsp_y, alu_y;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_f;

  logic       req0_ready4, req1_ready4, rsp_valid4, rsp_id4, rsp_err4, busy4;
  logic [8:0] rsp_y4, alu_y4;
  logic [7:0] alu_a4, alu_b4;
  logic [3:0] alu_f4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_fn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, a} * {8'd0, b};
    case (f)
      4'd0:    return {1'b0, a & b};
      4'd1:    return {1'b0, a | b};
      4'd2:    return {1'b0, a ^ b};
      4'd3:    return {1'b0, ~(a & b)};
      4'd4:    return {1'b0, ~(a | b)};
      4'd5:    return {1'b0, a} + {1'b0, b};
      4'd6:    return {1'b0, a} - {1'b0, b};
      4'd7:    return p[8:0];
      4'd8:    return (b == 8'd0) ? 9'h1FF : {1'b0, a / b};
      default: return 9'h155;
    endcase
  endfunction

  assign alu_y  = alu_fn(alu_f, alu_a, alu_b);
  assign alu_y4 = alu_fn(alu_f4, alu_a4, alu_b4);

  alu_sched #(.W(8), .FN_W(4), .ALU_LAT(1), .OP_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_f(req0_f), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_f(req1_f), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y), .busy(busy)
  );

  alu_sched #(.W(8), .FN_W(4), .ALU_LAT(4), .OP_MAX(8)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready4), .req0_f(req0_f), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready4), .req1_f(req1_f), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_y(rsp_y4), .rsp_id(rsp_id4), .rsp_err(rsp_err4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_f(alu_f4), .alu_y(alu_y4), .busy(busy4)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      total++;
      if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_err} !== 6'b0 || rsp_y !== 9'd0 ||
          alu_a !== 8'd0 || alu_b !== 8'd0 || alu_f !== 4'd0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got v=%b busy=%b rdy=%b%b y=%0d id=%b err=%b a=%0d b=%0d f=%0d want all 0",
                 i, rsp_valid, busy, req0_ready, req1_ready, rsp_y, rsp_id, rsp_err, alu_a, alu_b, alu_f);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_add();
    do_reset();
    rsp_ready = 1'b1;
    req0_f = 4'd5; req0_a = 8'd200; req0_b = 8'd100; req0_valid = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL add_accept got rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || alu_a !== 8'd200 || alu_b !== 8'd100 || alu_f !== 4'd5) begin
      bad++; $display("FAIL add_exec got v=%b busy=%b a=%0d b=%0d f=%0d want 0 1 200 100 5", rsp_valid, busy, alu_a, alu_b, alu_f);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_y !== 9'd300 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL add_rsp got v=%b y=%0d id=%b err=%b want 1 300 0 0", rsp_valid, rsp_y, rsp_id, rsp_err);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || alu_a !== 8'd200 || rsp_y !== 9'd300) begin
      bad++; $display("FAIL add_idle_hold got busy=%b v=%b a=%0d y=%0d want 0 0 200 300", busy, rsp_valid, alu_a, rsp_y);
    end
  endtask

  task automatic test_contention();
    int         k;
    logic       exp_id [4];
    logic [8:0] exp_y  [4];
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_y  = '{9'h030, 9'h03F, 9'h030, 9'h03F};
    k = 0;
    do_reset();
    rsp_ready = 1'b1;
    req0_f = 4'd0; req0_a = 8'hF0; req0_b = 8'h3C;
    req1_f = 4'd1; req1_a = 8'h0F; req1_b = 8'h30;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL rr_first got rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
    end
    for (int c = 0; c < 60 && k < 4; c++) begin
      @(negedge clk);
      total++;
      if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
        bad++; $display("FAIL rr_both_ready cyc=%0d got 1 1 want at most one", c);
      end
      if (rsp_valid === 1'b1) begin
        total++;
        if (rsp_id !== exp_id[k] || rsp_y !== exp_y[k] || rsp_err !== 1'b0) begin
          bad++; $display("FAIL rr_seq n=%0d got id=%b y=%h err=%b want id=%b y=%h err=0", k, rsp_id, rsp_y, rsp_err, exp_id[k], exp_y[k]);
        end
        k++;
      end
    end
    total++;
    if (k !== 4) begin
      bad++; $display("FAIL rr_timeout got %0d responses want 4", k);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    rsp_ready = 1'b0;
    req0_f = 4'd2; req0_a = 8'hAA; req0_b = 8'h0F; req0_valid = 1'b1;
    req1_f = 4'd5; req1_a = 8'd1;  req1_b = 8'd2;  req1_valid = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL bp_accept got rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_y !== 9'h0A5 || rsp_id !== 1'b0 || req1_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b y=%h id=%b rdy1=%b want 1 0a5 0 0", i, rsp_valid, rsp_y, rsp_id, req1_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req1_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      bad++; $display("FAIL bp_take_cycle got rdy1=%b v=%b want 0 1", req1_ready, rsp_valid);
    end
    @(negedge clk);
    total++;
    if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_next_grant got rdy1=%b v=%b want 1 0", req1_ready, rsp_valid);
    end
    @(posedge clk); #1 req1_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (rsp_valid !== 1'b1 || rsp_y !== 9'd3 || rsp_id !== 1'b1 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL bp_rsp1 got v=%b y=%0d id=%b err=%b want 1 3 1 0", rsp_valid, rsp_y, rsp_id, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal_div();
    logic       dz_err;
    logic [3:0] dz_f;
`ifdef ALU_DIVZERO_CHK_EN
    dz_err = 1'b1; dz_f = 4'd0;
`else
    dz_err = 1'b0; dz_f = 4'd8;
`endif
    do_reset();
    rsp_ready = 1'b1;
    // Illegal code: ALU sees AND of 0xFF,0xFF = 0xFF, result must still be forced to 0.
    req0_f = 4'hC; req0_a = 8'hFF; req0_b = 8'hFF; req0_valid = 1'b1;
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    total++;
    if (alu_f !== 4'd0 || alu_a !== 8'hFF) begin
      bad++; $display("FAIL ill_alu_f got f=%0d a=%h want 0 ff", alu_f, alu_a);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_y !== 9'd0 || rsp_err !== 1'b1) begin
      bad++; $display("FAIL ill_rsp got v=%b y=%0d err=%b want 1 0 1", rsp_valid, rsp_y, rsp_err);
    end
    @(negedge clk);
    // Highest legal code: 200/7 = 28.
    req0_f = 4'd8; req0_a = 8'd200; req0_b = 8'd7; req0_valid = 1'b1;
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_y !== 9'd28 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL div_rsp got v=%b y=%0d err=%b want 1 28 0", rsp_valid, rsp_y, rsp_err);
    end
    @(negedge clk);
    // Divide by zero.
    req0_f = 4'd8; req0_a = 8'd9; req0_b = 8'd0; req0_valid = 1'b1;
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    total++;
    if (alu_f !== dz_f) begin
      bad++; $display("FAIL divz_alu_f got %0d want %0d", alu_f, dz_f);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_y !== 9'd0 || rsp_err !== dz_err) begin
      bad++; $display("FAIL divz_rsp got v=%b y=%0d err=%b want 1 0 %b", rsp_valid, rsp_y, rsp_err, dz_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b0;
    req0_f = 4'd5; req0_a = 8'd1; req0_b = 8'd1; req0_valid = 1'b1;
    req1_f = 4'd1; req1_a = 8'd2; req1_b = 8'd2;
    #1;
    total++;
    if (req0_ready4 !== 1'b1) begin
      bad++; $display("FAIL rmid_accept got rdy0=%b want 1", req0_ready4);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if (busy4 !== 1'b1 || rsp_valid4 !== 1'b0) begin
      bad++; $display("FAIL rmid_exec got busy=%b v=%b want 1 0", busy4, rsp_valid4);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (busy4 !== 1'b0 || rsp_valid4 !== 1'b0 || alu_a4 !== 8'd0 || alu_f4 !== 4'd0) begin
      bad++; $display("FAIL rmid_clear got busy=%b v=%b a=%0d f=%0d want 0 0 0 0", busy4, rsp_valid4, alu_a4, alu_f4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid4 !== 1'b0 || busy4 !== 1'b0) begin
        bad++; $display("FAIL rmid_quiet cyc=%0d got v=%b busy=%b want 0 0", i, rsp_valid4, busy4);
      end
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++;
    if (req0_ready4 !== 1'b1 || req1_ready4 !== 1'b0) begin
      bad++; $display("FAIL rmid_ptr got rdy0=%b rdy1=%b want 1 0", req0_ready4, req1_ready4);
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_illegal_div();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
